adder_digit_serial: RTL and testbench
=====================================

# adder_digit_serial

Parametrised digit-serial adder, the sequential successor to the fixed-width combinational adders. Adds two NBITS-wide operands plus carry-in, DBITS bits per cycle, using a single DBITS-wide adder slice and a carry register. It provides sum, carry-out and signed overflow behind val/rdy handshakes on input and output, so it can sit between pipelined producers and consumers in area-constrained datapaths.

## Interface

- NBITS, 16, operand and sum width; must be a multiple of DBITS.
- DBITS, 4, digit width added per cycle; 1 <= DBITS <= NBITS.
- NDIGITS, NBITS/DBITS, derived and not overridable; cycles spent in CALC.

Ports:

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_val  in  1  operands valid.
- in_rdy  out  1  block can accept operands.
- in_a  in  NBITS  operand A.
- in_b  in  NBITS  operand B.
- in_cin  in  1  carry-in.
- out_val  out  1  result valid.
- out_rdy  in  1  consumer accepts result.
- out_sum  out  NBITS  (A + B + cin) mod 2^NBITS.
- out_cout  out  1  unsigned carry-out of the MSB.
- out_ovf  out  1  two's-complement overflow: A[MSB]==B[MSB] and sum[MSB]!=A[MSB].

## Operation

- FSM has three states: IDLE, CALC and DONE.
- IDLE:
  - in_rdy=1, out_val=0.
  - On in_val&&in_rdy at a clock edge: latch in_a, in_b; carry <= in_cin; digit counter <= 0; sum register <= 0; go to CALC.
- CALC:
  - in_rdy=0, out_val=0.
  - Each edge computes {c, s} = a[i*DBITS +: DBITS] + b[i*DBITS +: DBITS] + carry, for i = counter.
  - Writes s into sum digit i; carry <= c; counter++.
  - After digit NDIGITS-1: out_cout <= c, out_ovf computed from the completed sum, go to DONE.
- DONE:
  - out_val=1; out_sum, out_cout and out_ovf are held stable.
  - On out_rdy at an edge: go to IDLE.
- Only one transaction is in flight. in_a, in_b and in_cin are ignored outside the IDLE accept edge, so they may change freely after the accept edge.
- out_sum, out_cout and out_ovf hold their last values in IDLE and CALC, but are only meaningful while out_val=1.
- Digits are processed least-significant first. Carry propagates across digits exactly as in a ripple adder, so the result equals the single-cycle NBITS adder result.
- Wrap-around: the sum is truncated to NBITS; the dropped bit appears on out_cout.

## Timing

- Reset (rst_n=0, asynchronous):
  - state=IDLE; counter, carry, latched operands and the sum register are cleared to 0.
  - out_val=0, out_sum=0, out_cout=0, out_ovf=0.
  - in_rdy=0 while rst_n is low; in_rdy=1 from the first cycle after deassertion.
- Reset mid-operation (CALC or DONE): the transaction is discarded, with no out_val pulse after reset release.
- Latency (accept edge = E0):
  - Digit i is computed on edge E(i+1).
  - out_val rises after edge E(NDIGITS) and stays high until the out_rdy edge.
  - Minimum result-accept edge is E(NDIGITS+1).
  - in_rdy returns high in the cycle after the result is accepted.
  - Minimum period between accepts is NDIGITS+2 cycles: 6 for the defaults, 3 when DBITS=NBITS.
- Handshake:
  - A transfer occurs only when val and rdy are both high at an edge.
  - in_val may rise or fall at any time while in_rdy=0 without effect.
  - out_rdy high while out_val=0 has no effect.
  - out_rdy low in DONE stalls indefinitely with outputs unchanged.
- Simultaneous events: an out_rdy accept in DONE and an in_val in the same cycle do not overlap. The new operands are accepted no earlier than the following edge, in IDLE.
- There are no combinational paths from in_val to in_rdy or from out_rdy to out_val.

## Test plan

All scenarios use the defaults (NBITS=16, DBITS=4) unless noted.

- Basic: A=0x0002, B=0x0003, cin=0, out_rdy=1 -> out_val high 4 cycles after accept; sum=0x0005, cout=0, ovf=0; in_rdy low for exactly 5 cycles.
- Inter-digit carry chain: 0x0FFF+0x0001 -> 0x1000, cout=0, ovf=0. Then 0x5555+0xAAAB with cin=0 -> 0x0000, cout=1, ovf=0.
- Wrap, overflow and carry-in:
  - 0xFFFF+0x0001 -> 0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> 0x8000, cout=0, ovf=1.
  - 0x8000+0x8000 -> 0x0000, cout=1, ovf=1.
  - 0x0005+0x0007 with cin=1 -> 0x000D.
- Backpressure and operand isolation:
  - Hold out_rdy=0 for 5 cycles in DONE -> out_val stays 1, outputs stable, in_rdy=0.
  - Toggle in_a/in_b during CALC -> the result is unaffected.
- Reset mid-transaction: assert rst_n=0 asynchronously (off-edge) during CALC digit 2 -> all outputs 0 immediately. After release: in_rdy=1, no out_val pulse; the next transaction 0x1234+0x1111 -> 0x2345.
- Parameter sweep: DBITS=16 (1-cycle CALC), DBITS=1 (16-cycle CALC) and NBITS=8/DBITS=2. Each runs 200 random back-to-back transactions with random val/rdy stalls, checked against a reference model of a+b+cin.

Source files
------------

// File: rtl/adder_digit_serial.sv
// adder_digit_serial: NBITS adder computed DBITS bits per cycle behind val/rdy handshakes
module adder_digit_serial #(
    parameter int NBITS = 16,
    parameter int DBITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_a,
    input  logic [NBITS-1:0] in_b,
    input  logic             in_cin,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int NDIGITS = NBITS / DBITS;
    localparam int CW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state;
    logic [NBITS-1:0]       a_r, b_r, sum_r, sum_next;
    logic                   carry, last;
    logic [CW-1:0]          cnt;
    logic [DBITS:0]         dsum;
    logic [NBITS+DBITS-1:0] cat;

    // Single digit slice: operands shift right so the current digit is always the low one,
    // and finished digits enter the sum register from the top.
    always_comb begin
        dsum     = {1'b0, a_r[DBITS-1:0]} + {1'b0, b_r[DBITS-1:0]} + {{DBITS{1'b0}}, carry};
        cat      = {dsum[DBITS-1:0], sum_r};
        sum_next = cat[NBITS+DBITS-1:DBITS];
        last     = cnt == CW'(NDIGITS - 1);
    end

    // Control FSM with every handshake and result output registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sum_r    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            in_rdy   <= 1'b0;
            out_val  <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_rdy <= 1'b1;
                    if (in_val && in_rdy) begin
                        a_r    <= in_a;
                        b_r    <= in_b;
                        carry  <= in_cin;
                        cnt    <= '0;
                        sum_r  <= '0;
                        in_rdy <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    a_r   <= a_r >> DBITS;
                    b_r   <= b_r >> DBITS;
                    sum_r <= sum_next;
                    carry <= dsum[DBITS];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        out_sum  <= sum_next;
                        out_cout <= dsum[DBITS];
                        out_ovf  <= (a_r[DBITS-1] == b_r[DBITS-1]) && (dsum[DBITS-1] != a_r[DBITS-1]);
                        out_val  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        out_val <= 1'b0;
                        in_rdy  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_digit_serial.sv
// tb_adder_digit_serial: directed checks on the default adder plus random sweeps of three other widths
module tb_adder_digit_serial;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv, ir, ov, ordy, cin, cout, ovf;
    logic [15:0] a, b, sum;

    logic [2:0][15:0] sw_a, sw_b;
    logic [2:0]       sw_iv, sw_ir, sw_or, sw_ov, sw_cin, sw_cout, sw_ovf;
    logic [15:0]      s_d16, s_d1;
    logic [7:0]       s_n8;

    int          n_chk = 0, n_fail = 0;
    int          lat, n, pulses, cyc;
    int          acc[3], got[3];
    logic [17:0] q[$], sq0[$], sq1[$], sq2[$];
    logic [17:0] e;
    logic [15:0] m;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    adder_digit_serial dut (
        .clk(clk), .rst_n(rst_n), .in_val(iv), .in_rdy(ir), .in_a(a), .in_b(b), .in_cin(cin),
        .out_val(ov), .out_rdy(ordy), .out_sum(sum), .out_cout(cout), .out_ovf(ovf)
    );
    adder_digit_serial #(.NBITS(16), .DBITS(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_val(sw_iv[0]), .in_rdy(sw_ir[0]), .in_a(sw_a[0]), .in_b(sw_b[0]),
        .in_cin(sw_cin[0]), .out_val(sw_ov[0]), .out_rdy(sw_or[0]), .out_sum(s_d16),
        .out_cout(sw_cout[0]), .out_ovf(sw_ovf[0])
    );
    adder_digit_serial #(.NBITS(16), .DBITS(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_val(sw_iv[1]), .in_rdy(sw_ir[1]), .in_a(sw_a[1]), .in_b(sw_b[1]),
        .in_cin(sw_cin[1]), .out_val(sw_ov[1]), .out_rdy(sw_or[1]), .out_sum(s_d1),
        .out_cout(sw_cout[1]), .out_ovf(sw_ovf[1])
    );
    adder_digit_serial #(.NBITS(8), .DBITS(2)) u_n8 (
        .clk(clk), .rst_n(rst_n), .in_val(sw_iv[2]), .in_rdy(sw_ir[2]), .in_a(sw_a[2][7:0]),
        .in_b(sw_b[2][7:0]), .in_cin(sw_cin[2]), .out_val(sw_ov[2]), .out_rdy(sw_or[2]),
        .out_sum(s_n8), .out_cout(sw_cout[2]), .out_ovf(sw_ovf[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide addition, result packed as {ovf, cout, sum}
    function automatic logic [17:0] model(input int k, input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] t;
        t = {1'b0, x} + {1'b0, y} + {16'h0000, c};
        if (k == 2) return {x[7] == y[7] && t[7] != x[7], t[8], 8'h00, t[7:0]};
        return {x[15] == y[15] && t[15] != x[15], t[16], t[15:0]};
    endfunction

    function automatic logic [17:0] observe(input int k);
        if (k == 0) return {sw_ovf[0], sw_cout[0], s_d16};
        if (k == 1) return {sw_ovf[1], sw_cout[1], s_d1};
        return {sw_ovf[2], sw_cout[2], 8'h00, s_n8};
    endfunction

    function automatic int qsize(input int k);
        return k == 0 ? sq0.size() : k == 1 ? sq1.size() : sq2.size();
    endfunction

    task automatic qpush(input int k, input logic [17:0] v);
        if (k == 0) sq0.push_back(v);
        else if (k == 1) sq1.push_back(v);
        else sq2.push_back(v);
    endtask

    task automatic qpop(input int k, output logic [17:0] v);
        if (k == 0) v = sq0.pop_front();
        else if (k == 1) v = sq1.pop_front();
        else v = sq2.pop_front();
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic start(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                         input logic [15:0] es, input logic ec, input logic eo);
        int w = 0;
        q.push_back({eo, ec, es});
        a = ai; b = bi; cin = ci; iv = 1'b1;
        while (!ir && w < 50) begin @(posedge clk); #1; w++; end
        chk("in_rdy timeout", ir, 1);
        @(posedge clk); #1;
        iv = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int l);
        logic [17:0] x;
        l = 0;
        while (!ov && l < 100) begin @(posedge clk); #1; l++; end
        chk({tag, " out_val"}, ov, 1);
        chk({tag, " queue"}, q.size(), 1);
        x = q.pop_front();
        chk({tag, " sum"}, sum, x[15:0]);
        chk({tag, " cout"}, cout, x[16]);
        chk({tag, " ovf"}, ovf, x[17]);
    endtask

    task automatic take(output int k);
        ordy = 1'b1; k = 0;
        do begin @(posedge clk); #1; k++; end while (!ir && k < 50);
        ordy = 1'b0;
        chk("out_val drop", ov, 0);
    endtask

    task automatic run(input string tag, input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                       input logic [15:0] es, input logic ec, input logic eo);
        int l, k;
        start(ai, bi, ci, es, ec, eo);
        wait_out(tag, l);
        take(k);
    endtask

    initial begin
        rst_n = 1'b0; iv = 1'b0; ordy = 1'b0; a = '0; b = '0; cin = 1'b0;
        sw_a = '0; sw_b = '0; sw_iv = '0; sw_or = '0; sw_cin = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_rdy", ir, 0);
        chk("reset out_val", ov, 0);
        chk("reset out_sum", sum, 0);
        chk("reset cout/ovf", {cout, ovf}, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_rdy after reset", ir, 1);

        start(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0);
        wait_out("basic", lat);
        chk("basic latency", lat, 4);
        take(n);
        chk("basic in_rdy low cycles", lat + n, 5);

        run("carry chain", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
        run("full chain", 16'h5555, 16'hAAAB, 1'b0, 16'h0000, 1'b1, 1'b0);
        run("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run("pos ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run("neg ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run("carry in", 16'h0005, 16'h0007, 1'b1, 16'h000D, 1'b0, 1'b0);

        start(16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0);
        wait_out("stall", lat);
        iv = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall out_val", ov, 1);
            chk("stall out_sum", sum, 16'h3334);
            chk("stall in_rdy", ir, 0);
        end
        iv = 1'b0;
        take(n);

        start(16'h1357, 16'h2468, 1'b0, 16'h37BF, 1'b0, 1'b0);
        repeat (3) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
        end
        wait_out("isolation", lat);
        take(n);

        start(16'hAAAA, 16'h1111, 1'b0, 16'hBBBB, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid reset out_val", ov, 0);
        chk("mid reset out_sum", sum, 0);
        chk("mid reset cout/ovf", {cout, ovf}, 0);
        chk("mid reset in_rdy", ir, 0);
        q.delete();
        #10 rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (ov) pulses++;
        end
        chk("no out_val after reset", pulses, 0);
        chk("in_rdy after mid reset", ir, 1);
        run("post reset", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

        acc = '{0, 0, 0};
        got = '{0, 0, 0};
        cyc = 0;
        while ((got[0] < 200 || got[1] < 200 || got[2] < 200) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 3; k++) begin
                m = k == 2 ? 16'h00FF : 16'hFFFF;
                sw_iv[k] = acc[k] < 200 && $urandom_range(0, 3) != 0;
                sw_or[k] = $urandom_range(0, 3) != 0;
                sw_a[k] = 16'($urandom) & m;
                sw_b[k] = 16'($urandom) & m;
                sw_cin[k] = 1'($urandom);
                if (sw_iv[k] && sw_ir[k]) begin
                    qpush(k, model(k, sw_a[k], sw_b[k], sw_cin[k]));
                    acc[k]++;
                end
                if (sw_or[k] && sw_ov[k]) begin
                    if (qsize(k) == 0) chk($sformatf("sweep%0d spurious out_val", k), 1, 0);
                    else begin
                        qpop(k, e);
                        chk($sformatf("sweep%0d result", k), observe(k), e);
                        got[k]++;
                    end
                end
            end
        end
        sw_iv = '0;
        sw_or = '0;
        for (int k = 0; k < 3; k++) chk($sformatf("sweep%0d completed", k), got[k], 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
